ram_dump: RTL

- Sequential read-out engine for the 64x32 synchronous-read data RAM that the Fibonacci compute loop fills.
- Walks a contiguous address range, reads each word (1-cycle RAM read latency), and presents it on a valid/ready output stream with its address and a last flag.
- Sits on the RAM read port opposite the compute/writer path; typical consumers are a display or serial dumper.

---
 rtl/ram_dump.sv | 118 +++++++++++
 1 files changed

// File: rtl/ram_dump.sv
// Sequential read-out engine for a synchronous-read RAM. It walks a contiguous
// address range one word at a time, then streams each word out over valid/ready
// together with its address and a last flag.
module ram_dump #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam logic [ADDR_W:0]   MaxCount = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   RemOne   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StRd, StWt, StOut, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_last_q, out_last_d;
  logic [ADDR_W:0]     count_clamped;

  // Requests larger than the RAM read every word exactly once.
  assign count_clamped = (count > MaxCount) ? MaxCount : count;

  // Next-state logic: one RAM read per word, never more than one outstanding.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_last_d = out_last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count_clamped != '0) begin
            cur_d   = start_addr;
            rem_d   = count_clamped;
            state_d = StRd;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRd: state_d = StWt;
      StWt: begin
        // RAM data is valid this cycle, one cycle after the read enable.
        out_data_d = ram_dout;
        out_addr_d = cur_q;
        out_last_d = (rem_q == RemOne);
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (rem_q == RemOne) begin
            state_d = StFin;
          end else begin
            cur_d   = (cur_q == LastAddr) ? '0 : cur_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = StRd;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any dump in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      out_last_q <= out_last_d;
    end
  end

  // Status and handshake outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StFin);
    ram_en    = (state_q == StRd);
    out_valid = (state_q == StOut);
    ram_addr  = cur_q;
    out_data  = out_data_q;
    out_addr  = out_addr_q;
    out_last  = out_last_q;
  end

endmodule
